// File: rtl/vm_pkg.sv
// Shared definitions for the spiral-dispensing stages: FSM encoding, fault codes
// and default timing constants (also used by the relay stage).
package vm_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 50000;     // 1 ms at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES  = 25000000;  // 0.5 s at 50 MHz
    localparam int DEF_CNT_W           = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } giro_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ORDER   = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_code_t;

endpackage

// File: rtl/debounce_sensor.sv
// One raw optical sensor: 2-FF synchroniser, then a clean level that only follows
// the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_sensor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_clean
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_clean;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_clean <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any cycle where synced and clean agree restarts the stability window.
            if (r_sync2 != r_clean) begin
                if (r_cnt == LAST) begin
                    r_clean <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_clean = r_clean;

endmodule

// File: rtl/sensor_giro.sv
// Debounces both spiral sensors, checks s1-then-s2 ordering within a timeout and
// emits a registered one-cycle giro pulse, a saturating giro count and fault reports.
module sensor_giro
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             clear_in,
    input  logic             sensor1_in,
    input  logic             sensor2_in,
    output logic             sensor1_out,
    output logic             sensor2_out,
    output logic             giro_pulse_out,
    output logic [CNT_W-1:0] giro_count_out,
    output logic             fault_out,
    output logic [1:0]       fault_code_out
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             w_s1_clean, w_s2_clean;
    logic             r_s1_prev, r_s2_prev;
    logic             w_s1_rise, w_s2_rise;
    giro_state_t      r_state, w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic             w_timer_clr, w_giro, w_fault;
    fault_code_t      w_fault_code, r_fault_code;
    logic             r_giro_pulse, r_fault;
    logic [CNT_W-1:0] r_count;

    debounce_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s1 (
        .i_clk  (clock_in),
        .i_rst  (reset_in),
        .i_raw  (sensor1_in),
        .o_clean(w_s1_clean)
    );

    debounce_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s2 (
        .i_clk  (clock_in),
        .i_rst  (reset_in),
        .i_raw  (sensor2_in),
        .o_clean(w_s2_clean)
    );

    // Edge history runs regardless of enable so re-enabling over a high level is not a rise.
    assign w_s1_rise = w_s1_clean & ~r_s1_prev;
    assign w_s2_rise = w_s2_clean & ~r_s2_prev;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_clr  = 1'b0;
        w_giro       = 1'b0;
        w_fault      = 1'b0;
        w_fault_code = FAULT_NONE;
        if (!enable_in) begin
            w_state_nxt = ST_IDLE;
            w_timer_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s2_rise) begin
                        w_fault      = 1'b1;
                        w_fault_code = FAULT_ORDER;
                    end else if (w_s1_rise) begin
                        w_state_nxt = ST_ARMED;
                        w_timer_clr = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_s2_rise) begin
                        w_giro      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_s1_rise) begin
                        w_timer_clr = 1'b1;
                    end else if (r_timer == TMAX) begin
                        w_fault      = 1'b1;
                        w_fault_code = FAULT_TIMEOUT;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_s1_prev    <= 1'b0;
            r_s2_prev    <= 1'b0;
            r_timer      <= '0;
            r_giro_pulse <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_count      <= '0;
        end else begin
            r_s1_prev    <= w_s1_clean;
            r_s2_prev    <= w_s2_clean;
            r_giro_pulse <= w_giro;
            r_fault      <= w_fault;
            if (w_timer_clr || w_state_nxt != ST_ARMED) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_fault) begin
                r_fault_code <= w_fault_code;
            end
            if (clear_in) begin
                r_count <= '0;
            end else if (w_giro && r_count != CMAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sensor1_out    = w_s1_clean;
    assign sensor2_out    = w_s2_clean;
    assign giro_pulse_out = r_giro_pulse;
    assign giro_count_out = r_count;
    assign fault_out      = r_fault;
    assign fault_code_out = r_fault_code;

endmodule

// File: tb/tb_sensor_giro.sv
// Directed bench for sensor_giro with small debounce/timeout values; giro and fault
// events are predicted into a queue and matched as the DUT pulses them.
module tb_sensor_giro;

    localparam int DEB = 4;
    localparam int TO  = 20;
    localparam int CW  = 4;

    logic          clock_in = 1'b0;
    logic          reset_in, enable_in, clear_in, sensor1_in, sensor2_in;
    logic          sensor1_out, sensor2_out, giro_pulse_out, fault_out;
    logic [CW-1:0] giro_count_out;
    logic [1:0]    fault_code_out;

    typedef struct packed {
        logic          giro;
        logic          fault;
        logic [1:0]    code;
        logic [CW-1:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         m_cnt       = 0;
    int         m_giros     = 0;
    int         n_giros     = 0;
    logic [1:0] m_code      = 2'b00;

    sensor_giro #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .enable_in     (enable_in),
        .clear_in      (clear_in),
        .sensor1_in    (sensor1_in),
        .sensor2_in    (sensor2_in),
        .sensor1_out   (sensor1_out),
        .sensor2_out   (sensor2_out),
        .giro_pulse_out(giro_pulse_out),
        .giro_count_out(giro_count_out),
        .fault_out     (fault_out),
        .fault_code_out(fault_code_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; outputs sampled on the falling edge, every pulse matched to the queue.
    task automatic tick(input int n = 1);
        ev_t obs;
        ev_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            if (giro_pulse_out || fault_out) begin
                obs = {giro_pulse_out, fault_out, fault_code_out, giro_count_out};
                if (giro_pulse_out) n_giros++;
                if (exp_q.size() == 0) begin
                    check("spurious_event", 32'(obs), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(obs), 32'(e));
                end
            end
        end
    endtask

    task automatic drive(input logic s1, input logic s2, input int n);
        sensor1_in = s1;
        sensor2_in = s2;
        tick(n);
    endtask

    task automatic push_giro();
        ev_t e;
        m_giros++;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        e = {1'b1, 1'b0, m_code, CW'(m_cnt)};
        exp_q.push_back(e);
    endtask

    task automatic push_fault(input logic [1:0] code);
        ev_t e;
        m_code = code;
        e = {1'b0, 1'b1, code, CW'(m_cnt)};
        exp_q.push_back(e);
    endtask

    task automatic giro_seq();
        drive(1'b1, 1'b0, 8);
        drive(1'b1, 1'b1, 8);
        drive(1'b0, 1'b0, 10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s1"},    32'(sensor1_out),    32'(0));
        check({tag, "_s2"},    32'(sensor2_out),    32'(0));
        check({tag, "_giro"},  32'(giro_pulse_out), 32'(0));
        check({tag, "_fault"}, 32'(fault_out),      32'(0));
        check({tag, "_count"}, 32'(giro_count_out), 32'(0));
        check({tag, "_code"},  32'(fault_code_out), 32'(0));
    endtask

    initial begin
        int n0;
        reset_in   = 1'b1;
        enable_in  = 1'b1;
        clear_in   = 1'b0;
        sensor1_in = 1'b0;
        sensor2_in = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset_in = 1'b0;
        tick(50);
        check_all_zero("idle50");

        // 3-cycle glitch must never reach the clean level
        sensor1_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("glitch_s1", 32'(sensor1_out), 32'(0));
        end
        sensor1_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_s1", 32'(sensor1_out), 32'(0));
        end

        // Latency: clean level changes 2+DEB cycles after raw; disabled so no arming
        enable_in  = 1'b0;
        sensor1_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("s1_latency", 32'(sensor1_out), 32'(i == 6));
        end
        tick(4);
        sensor1_in = 1'b0;
        tick(10);
        check("s1_fall", 32'(sensor1_out), 32'(0));
        enable_in = 1'b1;

        push_giro();
        giro_seq();
        check("count_after_1", 32'(giro_count_out), 32'(1));

        push_fault(2'b01);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 10);
        check("order_code", 32'(fault_code_out), 32'(2'b01));
        check("order_count", 32'(giro_count_out), 32'(1));

        push_fault(2'b10);
        drive(1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 30);
        check("timeout_code", 32'(fault_code_out), 32'(2'b10));

        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        m_cnt = 0;
        check("clear_count", 32'(giro_count_out), 32'(0));

        n0 = n_giros;
        for (int g = 0; g < 17; g++) begin
            push_giro();
            giro_seq();
        end
        check("sat_count", 32'(giro_count_out), 32'(15));
        check("sat_pulses", 32'(n_giros - n0), 32'(17));

        // Clear held across the 18th giro: clear wins on the coincident cycle
        begin
            ev_t e;
            m_giros++;
            m_cnt = 0;
            e = {1'b1, 1'b0, m_code, CW'(0)};
            exp_q.push_back(e);
        end
        clear_in = 1'b1;
        giro_seq();
        clear_in = 1'b0;
        check("clear_with_giro", 32'(giro_count_out), 32'(0));

        // Arm, drop enable, then s2 alone must be an order fault
        drive(1'b1, 1'b0, 8);
        enable_in = 1'b0;
        drive(1'b0, 1'b0, 5);
        enable_in = 1'b1;
        push_fault(2'b01);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 10);

        // Enable rising over an already-high s1 is not a rise
        enable_in = 1'b0;
        drive(1'b1, 1'b0, 8);
        enable_in = 1'b1;
        push_fault(2'b01);
        drive(1'b1, 1'b1, 8);
        drive(1'b0, 1'b0, 10);
        check("enable_code", 32'(fault_code_out), 32'(2'b01));

        push_giro();
        giro_seq();
        check("pre_reset_count", 32'(giro_count_out), 32'(1));

        // Reset while armed: everything zero, no later timeout
        drive(1'b1, 1'b0, 8);
        reset_in   = 1'b1;
        sensor1_in = 1'b0;
        tick(1);
        check_all_zero("reset_armed");
        reset_in = 1'b0;
        m_cnt    = 0;
        m_code   = 2'b00;
        drive(1'b0, 1'b0, 30);
        check("post_reset_code", 32'(fault_code_out), 32'(0));

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        check("total_giros", 32'(n_giros), 32'(m_giros));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sensor_giro.md
Name: sensor_giro

Overview:
- Conditions the two raw optical sensors of the dispensing spiral and produces clean sensor levels plus a one-cycle pulse per completed spiral rotation (giro).
- Sits directly upstream of the relay/rotation-counting stage.
- Replaces direct use of raw sensor pins with synchronised, debounced, order-checked events.
- Also reports ordering and timeout faults.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a clean level changes (1 ms at 50 MHz).
- TIMEOUT_CYCLES, 25000000, maximum cycles allowed between sensor1 rise and sensor2 rise (0.5 s).
- CNT_W, 4, width of the saturating giro counter.

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  synchronous, active-high reset
- enable_in  input  1  high while the relay is energised; when low, events are ignored
- clear_in  input  1  synchronous clear of giro_count_out
- sensor1_in  input  1  raw sensor 1, asynchronous, bouncing
- sensor2_in  input  1  raw sensor 2, asynchronous, bouncing
- sensor1_out  output  1  debounced sensor 1 level
- sensor2_out  output  1  debounced sensor 2 level
- giro_pulse_out  output  1  one-cycle pulse per valid rotation
- giro_count_out  output  CNT_W  saturating count of valid rotations
- fault_out  output  1  one-cycle pulse on order error or timeout
- fault_code_out  output  2  last fault: 00 none, 01 order, 10 timeout; held until next fault or reset

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM in IDLE, all counters 0, synchroniser and clean levels 0.
- Per channel:
  - 2-FF synchroniser feeds the debounce counter.
  - When the synced value differs from the clean level, the counter increments. It clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the clean level toggles on the next edge and the counter clears.
  - Latency from raw input becoming stable to clean output change is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches the clean output.
- Edge detect: a rise is a registered clean level going 0->1. Only rises are used.
- FSM states IDLE and ARMED; timeout counter active only in ARMED.
  - IDLE, s1 rise, no s2 rise: go to ARMED, timer = 0.
  - IDLE, s2 rise (with or without s1 rise): fault_out pulse, code 01, stay IDLE.
  - ARMED, s2 rise (s1 rise in the same cycle ignored): giro_pulse_out pulse, count+1, go to IDLE.
  - ARMED, s1 rise only: restart timer (re-arm), stay ARMED.
  - ARMED, timer = TIMEOUT_CYCLES-1 with no s2 rise: fault_out pulse, code 10, go to IDLE.
- Timing of pulses: giro_pulse_out and fault_out are registered. Each asserts exactly one cycle, the cycle after the clean rise is detected.
- giro_count_out:
  - Saturates at 2^CNT_W-1; further valid giros still pulse giro_pulse_out.
  - clear_in zeroes the count.
  - clear_in coincident with a giro: clear wins, count = 0.
- enable_in low:
  - FSM is forced to IDLE and the timer cleared.
  - No giro or fault events are generated.
  - Debounce and clean outputs keep running.
  - enable_in rising with the sensor already high does not create a rise; rises are edges only.
- Reset mid-ARMED: returns to IDLE with no pulse; fault_code_out cleared.

Decomposition:
- Shared package vm_pkg holds:
  - FSM state encoding (ST_IDLE, ST_ARMED);
  - fault codes (FAULT_NONE, FAULT_ORDER, FAULT_TIMEOUT);
  - default timing constants, shared with the relay stage.
- One sub-module, debounce_sensor (synchroniser + debounce counter + clean level register), instantiated twice.
- FSM, timer and counter live in sensor_giro.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
- Reset then idle, enable_in=1, sensors 0 -> all outputs 0 for 50 cycles.
- Raw sensor1 pulses high for 3 cycles, then low -> sensor1_out stays 0, no events. Held high for 10 cycles -> sensor1_out rises 6 cycles after the raw rise.
- Clean s1 rise, then clean s2 rise 8 cycles later -> exactly one giro_pulse_out cycle, giro_count_out=1, fault_out never asserted.
- s2 rise while IDLE -> fault_out one cycle, fault_code_out=01, count unchanged. Then s1 rise and no s2 for 20 cycles -> fault_out, fault_code_out=10, FSM back to IDLE.
- 17 valid giros with CNT_W=4 -> count saturates at 15 with 17 pulses observed. Then clear_in together with an 18th giro -> count=0.
- ARMED, then enable_in dropped for 5 cycles, then s2 rise after re-enable -> order fault (01), no giro pulse. Separately, reset_in asserted while ARMED -> no pulse, all outputs 0 next cycle.
